// File: rtl/gf2_pkg.sv
// Shared types and widths for the GF(2) divider scheduler.
//   DIVIDEND_W / DIVISOR_W : operand widths presented to the divider
//   QUOT_W / REM_W         : meaningful quotient / remainder bits returned
//   ID_W                   : requester index width (up to 8 requesters)
package gf2_pkg;

    localparam int unsigned DIVIDEND_W = 64;
    localparam int unsigned DIVISOR_W  = 25;
    localparam int unsigned QUOT_W     = 40;
    localparam int unsigned REM_W      = 24;
    localparam int unsigned ID_W       = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        RECOVER,
        RESP
    } sched_state_t;

    // Response payload held stable while rsp_valid is high.
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              error;
        logic [QUOT_W-1:0] quotient;
        logic [REM_W-1:0]  remainder;
    } rsp_t;

endpackage

// File: rtl/gf2_rr_arb.sv
// Round-robin arbiter: picks the first asserted request at or after ptr.
//   req   : per-requester request vector
//   ptr   : index with highest priority this cycle (must be < N_REQ)
//   grant : one-hot grant, zero when nothing requests
//   idx   : binary index of the granted requester
//   any   : at least one request is asserted
module gf2_rr_arb
    import gf2_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int unsigned      cand;
    logic [N_REQ-1:0] rot;

    // Walk the requesters starting at ptr, wrapping once; first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        rot   = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = 32'(ptr) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            rot = req >> cand;
            if (!any && rot[0]) begin
                any   = 1'b1;
                idx   = ID_W'(cand);
                grant = N_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/gf2_div_scheduler.sv
// Shares one GF(2) polynomial divider between N_REQ requesters.
//   req_*  : per-requester valid / combinational one-hot ready / flattened operands
//   rsp_*  : response (id, quotient, remainder, error) held until rsp_ready
//   div_*  : divider interface (start pulse, active-low reset, operands, results)
// A job with divisor bit 24 clear is answered with an error without touching the
// divider; a divider that never finishes is reset by the watchdog and answered
// with an error.
module gf2_div_scheduler
    import gf2_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*DIVIDEND_W-1:0]   req_divident,
    input  logic [N_REQ*DIVISOR_W-1:0]    req_divisor,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [QUOT_W-1:0]             rsp_quotient,
    output logic [REM_W-1:0]              rsp_remainder,
    output logic                          rsp_error,
    output logic                          div_start,
    output logic                          div_resetN,
    output logic [DIVIDEND_W-1:0]         div_divident,
    output logic [DIVISOR_W-1:0]          div_divisor,
    input  logic                          div_finish,
    input  logic [DIVIDEND_W-1:0]         div_quotient,
    input  logic [DIVIDEND_W-1:0]         div_reminder
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_t        state;
    logic [ID_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]    wd_cnt;
    rsp_t                rsp_q;

    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_any;
    logic [DIVIDEND_W-1:0] sel_dividend;
    logic [DIVISOR_W-1:0]  sel_divisor;

    // Upper divider result bits carry no information for a degree-24 divisor.
    logic unused_bits;
    assign unused_bits = ^{div_quotient[DIVIDEND_W-1:QUOT_W], div_reminder[DIVIDEND_W-1:REM_W]};

    gf2_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Grant is only offered while idle, so at most one job is ever in flight.
    assign req_ready = (state == IDLE && !reset) ? grant : '0;

    // Operand mux for the granted slot.
    assign sel_dividend = DIVIDEND_W'(req_divident >> (32'(gnt_idx) * DIVIDEND_W));
    assign sel_divisor  = DIVISOR_W'(req_divisor >> (32'(gnt_idx) * DIVISOR_W));

    assign rsp_id        = rsp_q.id;
    assign rsp_error     = rsp_q.error;
    assign rsp_quotient  = rsp_q.quotient;
    assign rsp_remainder = rsp_q.remainder;

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            wd_cnt       <= '0;
            rsp_q        <= '0;
            rsp_valid    <= 1'b0;
            div_start    <= 1'b0;
            div_resetN   <= 1'b0;
            div_divident <= '0;
            div_divisor  <= '0;
        end else begin
            div_start  <= 1'b0;
            div_resetN <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        div_divident <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        rsp_q.id     <= gnt_idx;
                        rr_ptr       <= (32'(gnt_idx) + 32'd1 >= N_REQ) ? '0 : gnt_idx + ID_W'(1);
                        // Without the leading term the divisor is not degree 24.
                        if (!sel_divisor[DIVISOR_W-1]) begin
                            state           <= RESP;
                            rsp_valid       <= 1'b1;
                            rsp_q.error     <= 1'b1;
                            rsp_q.quotient  <= '0;
                            rsp_q.remainder <= '0;
                        end else begin
                            state     <= START;
                            div_start <= 1'b1;
                        end
                    end
                end
                START: begin
                    // div_finish is still high from the idle divider here.
                    state  <= WAIT;
                    wd_cnt <= '0;
                end
                WAIT: begin
                    // Finish takes priority over an expiring watchdog.
                    if (div_finish) begin
                        state           <= RESP;
                        rsp_valid       <= 1'b1;
                        rsp_q.error     <= 1'b0;
                        rsp_q.quotient  <= div_quotient[QUOT_W-1:0];
                        rsp_q.remainder <= div_reminder[REM_W-1:0];
                    end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state      <= RECOVER;
                        div_resetN <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                RECOVER: begin
                    state           <= RESP;
                    rsp_valid       <= 1'b1;
                    rsp_q.error     <= 1'b1;
                    rsp_q.quotient  <= '0;
                    rsp_q.remainder <= '0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
